// File: rtl/dpa_pkg.sv
// Shared definitions for the DPA result stage: default widths, flag bit positions
// and the output-buffer occupancy states.
package dpa_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_OP_LEN = 5;
  localparam int DEF_CNT_W  = 16;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_N    = 3;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HEAD  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/dpa_result_stage_if.sv
// Handshake and status bundle between the DPA adder, the result stage and its consumer.
// The slave modport is the result stage's view; master is the surrounding environment.
interface dpa_result_stage_if #(
  parameter int WIDTH  = 32,
  parameter int OP_LEN = 5,
  parameter int CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_LEN-1:0] in_opcode;
  logic [WIDTH-1:0]  in_sum;
  logic              in_cout;
  logic              in_neg;
  logic              in_ovf;
  logic              in_zero;

  logic              out_valid;
  logic              out_ready;
  logic [OP_LEN-1:0] out_opcode;
  logic [WIDTH-1:0]  out_sum;
  logic [3:0]        out_flags;

  logic [3:0]        sticky_flags;
  logic              sticky_clr;
  logic [CNT_W-1:0]  result_cnt;
  logic              trap;
  logic              trap_ack;

  modport slave (
    input  in_valid, in_opcode, in_sum, in_cout, in_neg, in_ovf, in_zero,
    input  out_ready, sticky_clr, trap_ack,
    output in_ready, out_valid, out_opcode, out_sum, out_flags,
    output sticky_flags, result_cnt, trap
  );

  modport master (
    output in_valid, in_opcode, in_sum, in_cout, in_neg, in_ovf, in_zero,
    output out_ready, sticky_clr, trap_ack,
    input  in_ready, out_valid, out_opcode, out_sum, out_flags,
    input  sticky_flags, result_cnt, trap
  );

endinterface

// File: rtl/dpa_skid_buf.sv
// Two-entry skid buffer (head register + skid register) with a registered in_ready,
// so the upstream side never sees a combinational path from out_ready.
module dpa_skid_buf
  import dpa_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_WIDTH + DEF_OP_LEN + NUM_FLAGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 hold,
  output logic                 accept,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  state_e                 state_p0;
  state_e                 state_nx;
  logic                   in_ready_p0;
  logic [PAYLOAD_W-1:0]   head_p0;
  logic [PAYLOAD_W-1:0]   skid_p0;
  logic                   handoff;
  logic                   load_head;
  logic                   load_skid;
  logic                   head_from_skid;

  assign accept    = in_valid && in_ready_p0;
  assign handoff   = (state_p0 != EMPTY) && out_ready;
  assign in_ready  = in_ready_p0;
  assign out_valid = (state_p0 != EMPTY);
  assign out_data  = head_p0;

  always_comb begin
    state_nx       = state_p0;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state_p0)
      EMPTY: begin
        if (accept) begin
          state_nx  = HEAD;
          load_head = 1'b1;
        end
      end
      HEAD: begin
        if (accept && handoff) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (handoff) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path can fire
        if (handoff) begin
          state_nx       = HEAD;
          head_from_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // stage boundary: occupancy and upstream ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0    <= EMPTY;
      in_ready_p0 <= 1'b1;
    end else begin
      state_p0    <= state_nx;
      in_ready_p0 <= (state_nx != FULL) && !hold;
    end
  end

  // stage boundary: held payloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (load_head) begin
        head_p0 <= in_data;
      end else if (head_from_skid) begin
        head_p0 <= skid_p0;
      end
      if (load_skid) begin
        skid_p0 <= in_data;
      end
    end
  end

endmodule

// File: rtl/dpa_result_stage.sv
// Registered result stage behind the DPA adder: skid-buffered handshake, sticky N/Z/C/V,
// saturating result counter. Overflow trap enabled by defining DPA_RESULT_OVF_TRAP_EN.
module dpa_result_stage
  import dpa_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int OP_LEN = DEF_OP_LEN,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  dpa_result_stage_if.slave bus
);

  localparam int PAYLOAD_W = WIDTH + OP_LEN + NUM_FLAGS;

  logic [NUM_FLAGS-1:0] in_flags;
  logic [PAYLOAD_W-1:0] in_data;
  logic [PAYLOAD_W-1:0] head_data;
  logic                 accept;
  logic                 in_ready;
  logic                 out_valid;
  logic [NUM_FLAGS-1:0] sticky_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic                 trap_p0;
  logic                 trap_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_N] = bus.in_neg;
    in_flags[FLAG_Z] = bus.in_zero;
    in_flags[FLAG_C] = bus.in_cout;
    in_flags[FLAG_V] = bus.in_ovf;
  end

  assign in_data = {bus.in_opcode, bus.in_sum, in_flags};

  dpa_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .hold      (trap_nx),
    .accept    (accept),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head_data)
  );

`ifdef DPA_RESULT_OVF_TRAP_EN
  // ack only matters while a trap is pending; a new trap can only arm while clear
  assign trap_nx = trap_p0 ? !bus.trap_ack : (accept && bus.in_ovf);
`else
  logic unused_trap_ack;
  assign unused_trap_ack = bus.trap_ack;
  assign trap_nx         = 1'b0;
`endif

  // stage boundary: status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_p0 <= '0;
      cnt_p0    <= '0;
      trap_p0   <= 1'b0;
    end else begin
      trap_p0 <= trap_nx;
      if (bus.sticky_clr) begin
        sticky_p0 <= accept ? in_flags : '0;
        cnt_p0    <= accept ? CNT_W'(1) : '0;
      end else if (accept) begin
        sticky_p0 <= sticky_p0 | in_flags;
        cnt_p0    <= sat_inc(cnt_p0);
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_flags    = head_data[NUM_FLAGS-1:0];
  assign bus.out_sum      = head_data[WIDTH+NUM_FLAGS-1:NUM_FLAGS];
  assign bus.out_opcode   = head_data[PAYLOAD_W-1:WIDTH+NUM_FLAGS];
  assign bus.sticky_flags = sticky_p0;
  assign bus.result_cnt   = cnt_p0;
  assign bus.trap         = trap_p0;

endmodule

// File: doc/dpa_result_stage.md
# dpa_result_stage

Registered output stage placed directly downstream of the combinational DPA adder/ALU (`top`). It captures `final_sum`, `cout` and the N/Z/V flags for each issued operation through a valid/ready handshake and absorbs back-pressure with a 2-entry skid buffer. It also keeps sticky status flags and a saturating result counter for the consumer, typically register-file writeback or a status CSR.

## Interface
Parameters:
- `WIDTH`, 32, data width; matches the adder.
- `OP_LEN`, 5, opcode width.
- `CNT_W`, 16, result counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock domain; reset is asynchronous and active-low.
- `in_valid`  in  1  adder result presented.
- `in_ready`  out  1  stage can accept a beat.
- `in_opcode`  in  OP_LEN  opcode that produced the result.
- `in_sum`  in  WIDTH  adder `final_sum`.
- `in_cout`, `in_neg`, `in_ovf`, `in_zero`  in  1 each  adder flags.
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  consumer accepts.
- `out_opcode`  out  OP_LEN  registered opcode.
- `out_sum`  out  WIDTH  registered sum.
- `out_flags`  out  4  {N,Z,C,V} of the head beat.
- `sticky_flags`  out  4  {N,Z,C,V} ORed over all accepted beats since the last clear.
- `sticky_clr`  in  1  clears `sticky_flags` and `result_cnt`.
- `result_cnt`  out  CNT_W  accepted beats, saturating.
- `trap`  out  1  overflow trap pending (see Configuration).
- `trap_ack`  in  1  releases the trap.

## Operation
- Accept occurs when `in_valid && in_ready`. Output handoff occurs when `out_valid && out_ready`.
- FSM states:
  - EMPTY: nothing held.
  - HEAD: output register full, skid empty.
  - FULL: both the output register and the skid entry are full.
- Transitions:
  - EMPTY→HEAD on accept.
  - HEAD→EMPTY on handoff without accept.
  - HEAD→FULL on accept without handoff.
  - HEAD→HEAD on accept with handoff; the new beat replaces the head.
  - FULL→HEAD on handoff; the skid entry moves to the head.
- `in_ready` is registered. It equals (state != FULL) && !trap, so the stage never combinationally depends on `out_ready`.
- Order is strictly preserved. No beat is dropped or duplicated.
- Sticky flags:
  - On each accept, `sticky_flags |= {neg,zero,cout,ovf}`.
  - `sticky_clr` with no accept → 0.
  - `sticky_clr` in the same cycle as an accept → flags of the new beat only.
- Result counter:
  - Increments on accept and holds at 2^CNT_W−1.
  - `sticky_clr` with no accept → 0.
  - `sticky_clr` in the same cycle as an accept → 1.
- Flags pass through unmodified. The stage does no arithmetic on `in_sum`.

## Timing
- Latency: a beat accepted at edge k is visible on `out_*` with `out_valid`=1 after edge k when the stage was EMPTY, or when the stage was in HEAD and a handoff occurred in the same cycle.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Reset values:
  - `out_valid`=0, `in_ready`=1, `trap`=0.
  - `out_sum`, `out_opcode`, `out_flags`, `sticky_flags`, `result_cnt` = 0.
  - State = EMPTY.
- Reset mid-operation: all held beats are discarded immediately, with no flush cycle.
- `out_*` data is stable while `out_valid && !out_ready`.

## Configuration
- Macro: `DPA_RESULT_OVF_TRAP_EN`.
- Defined:
  - Accepting a beat with `in_ovf`=1 sets `trap` at the next edge.
  - While `trap`=1, `in_ready`=0. Already-held beats still drain.
  - `trap_ack` high for one cycle clears `trap` at the next edge.
  - `in_ready` returns to 1 the cycle after, provided the state is not FULL.
  - `trap_ack` while `trap`=0 is ignored.
- Undefined: `trap` is tied 0, `trap_ack` is ignored, and the port list is unchanged.

## Structure
- Package `dpa_pkg` holds:
  - `WIDTH`/`OP_LEN` defaults.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - The FSM state enum (EMPTY, HEAD, FULL).
- One sub-module, `dpa_skid_buf`, holds the 2-entry register pair and the FSM, parameterised on the payload width (WIDTH+OP_LEN+4).
- Sticky flags, the counter and the trap logic stay in `dpa_result_stage`.

## Test plan
- **Simple beat:** opcode 00001, sum 25 (0x19), flags 0, `out_ready`=1 → one cycle later `out_sum`=25, `out_flags`=0000, `result_cnt`=1.
- **Negative result:** sum 0xFFFFFFF5 with neg=1 (−12+1) → `out_flags`=1000. Then sum 11 with cout=1 (12+(−1)) → `sticky_flags`=1010.
- **Back-pressure:** `out_ready`=0 and three consecutive `in_valid` beats 1, 2, 3 → beats 1 and 2 accepted, `in_ready`=0, beat 3 held. Release `out_ready` → outputs 1, 2, 3 in order, no gaps after the first.
- **Sticky clear:** `sticky_clr` in the same cycle as an accept with zero=1 → `sticky_flags`=0100, `result_cnt`=1.
- **Saturation:** with CNT_W=4, accept 20 beats → `result_cnt`=15.
- **Trap (macro defined):** sum 0x80000000 with ovf=1 and neg=1 (0x7FFFFFFF+1) → `trap`=1 and `in_ready`=0 until `trap_ack`. Without the macro → `trap` stays 0.
